// File: rtl/clk_div_pkg.sv
// Shared types, ratio codes, FSM encoding and mask helper for the clock-enable divider.
package clk_div_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned RATIO_W = 2;

  typedef logic [RATIO_W-1:0] ratio_t;
  typedef logic [PHASE_W-1:0] phase_t;

  localparam ratio_t RATIO_DIV2  = 2'd0;
  localparam ratio_t RATIO_DIV4  = 2'd1;
  localparam ratio_t RATIO_DIV8  = 2'd2;
  localparam ratio_t RATIO_DIV16 = 2'd3;

  localparam phase_t PHASE_LAST = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Low-bit mask whose all-ones match marks the last phase of a divide period.
  function automatic phase_t ratio_mask(input ratio_t r);
    phase_t m;
    m = 4'hF;
    case (r)
      RATIO_DIV2:  m = 4'h1;
      RATIO_DIV4:  m = 4'h3;
      RATIO_DIV8:  m = 4'h7;
      RATIO_DIV16: m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Run control, ratio-change handshake and status bundle of the clock-enable divider.
interface clk_div_ctrl_if;
  import clk_div_pkg::*;

  logic   run;
  logic   cfg_valid;
  ratio_t cfg_ratio;
  logic   cfg_ready;
  logic   tick_en;
  ratio_t active_ratio;
  phase_t phase;
  logic   busy;
  logic   switch_done;

  modport master (
    output run, cfg_valid, cfg_ratio,
    input  cfg_ready, tick_en, active_ratio, phase, busy, switch_done
  );

  modport slave (
    input  run, cfg_valid, cfg_ratio,
    output cfg_ready, tick_en, active_ratio, phase, busy, switch_done
  );

endinterface

// File: rtl/clk_div_ctrl_phase_counter.sv
// Free-running 4-bit phase counter with enable and synchronous clear (clear wins).
module div_phase_counter
  import clk_div_pkg::*;
(
  input  logic   clk_in,
  input  logic   en,
  input  logic   clr,
  output phase_t phase
);

  phase_t phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-enable divider: glitch-free ratio switching aligned to the 16-cycle phase boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst,
  clk_div_ctrl_if.slave bus
);

  state_e state_q, state_d;
  ratio_t pend_q, pend_d;
  ratio_t active_q, active_d;
  logic   done_q, done_d;
  logic   cnt_clr_c;
  phase_t phase_c;
  phase_t mask_c;

  div_phase_counter u_cnt (
    .clk_in (clk_in),
    .en     (bus.run),
    .clr    (rst | cnt_clr_c),
    .phase  (phase_c)
  );

  // Next-state, pending capture and switch application.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    active_d  = active_q;
    done_d    = 1'b0;
    cnt_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          pend_d = bus.cfg_ratio;
          if (bus.cfg_ratio != active_q) begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        // Stopped clock has no boundary to wait for, so apply at once and restart phase.
        if (!bus.run) begin
          active_d  = pend_q;
          done_d    = 1'b1;
          cnt_clr_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (phase_c == PHASE_LAST) begin
          active_d = pend_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= RATIO_DIV2;
      active_q <= RATIO_DIV2;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign mask_c = ratio_mask(active_q);

  assign bus.tick_en      = bus.run & ((phase_c & mask_c) == mask_c);
  assign bus.cfg_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q == ST_PEND);
  assign bus.active_ratio = active_q;
  assign bus.phase        = phase_c;
  assign bus.switch_done  = done_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized bench for clk_div_ctrl against an arithmetic reference model.
module tb_clk_div_ctrl;

  logic clk_in;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: phase as integer, ratio as divide exponent minus one.
  int m_phase;
  int m_ratio;
  int m_pend;
  bit m_busy;
  bit m_done;

  clk_div_ctrl_if bus ();

  clk_div_ctrl dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_tick();
    int period;
    period = 2 << m_ratio;
    return (bus.run && ((m_phase + 1) % period == 0)) ? 1 : 0;
  endfunction

  task automatic check_all();
    #1;
    chk("phase",        32'(bus.phase),        32'(m_phase));
    chk("active_ratio", 32'(bus.active_ratio), 32'(m_ratio));
    chk("busy",         32'(bus.busy),         32'(m_busy));
    chk("cfg_ready",    32'(bus.cfg_ready),    32'(!m_busy));
    chk("switch_done",  32'(bus.switch_done),  32'(m_done));
    chk("tick_en",      32'(bus.tick_en),      32'(exp_tick()));
  endtask

  // Advance the model by one rising edge using the inputs that were applied.
  task automatic model_edge();
    bit cleared;
    cleared = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_ratio = 0;
      m_pend  = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (!m_busy) begin
      if (bus.cfg_valid && int'(bus.cfg_ratio) != m_ratio) begin
        m_pend = int'(bus.cfg_ratio);
        m_busy = 1'b1;
      end
    end else if (!bus.run) begin
      m_ratio = m_pend;
      m_phase = 0;
      m_busy  = 1'b0;
      m_done  = 1'b1;
      cleared = 1'b1;
    end else if (m_phase == 15) begin
      m_ratio = m_pend;
      m_busy  = 1'b0;
      m_done  = 1'b1;
    end
    if (bus.run && !cleared) m_phase = (m_phase + 1) % 16;
  endtask

  task automatic step();
    check_all();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < 40 && m_phase != p; i++) step();
    chk("reach_phase", 32'(m_phase), 32'(p));
  endtask

  task automatic count_ticks(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.tick_en === 1'b1) cnt++;
      #0;
      step();
    end
  endtask

  initial begin
    int  cnt;
    bit  req_on;
    int  req_ratio;
    bit  acc;

    checks = 0;
    errors = 0;
    m_phase = 0; m_ratio = 0; m_pend = 0; m_busy = 1'b0; m_done = 1'b0;
    rst = 1'b1;
    bus.run = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd3;
    @(negedge clk_in);
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    bus.run = 1'b0;
    bus.cfg_valid = 1'b0;
    step();
    rst = 1'b0;
    steps(2);

    // Default /2 ratio: one strobe every two running cycles.
    bus.run = 1'b1;
    count_ticks(32, cnt);
    chk("div2_tick_count", 32'(cnt), 32'd16);

    // Switch to /16 requested mid-period.
    run_to_phase(4);
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd3;
    step();
    bus.cfg_valid = 1'b0;
    chk("busy_after_req", 32'(bus.busy), 32'd1);
    run_to_phase(0);
    chk("ratio_after_wrap", 32'(bus.active_ratio), 32'd3);
    steps(1);
    count_ticks(32, cnt);
    chk("div16_tick_count", 32'(cnt), 32'd2);

    // Request landing exactly on the boundary waits a full period.
    run_to_phase(15);
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd1;
    step();
    bus.cfg_valid = 1'b0;
    chk("no_switch_same_wrap", 32'(bus.active_ratio), 32'd3);
    steps(15);
    chk("still_pending", 32'(bus.busy), 32'd1);
    steps(1);
    chk("switch_next_wrap", 32'(bus.active_ratio), 32'd1);

    // Stopped clock: ratio applies immediately and phase restarts.
    steps(3);
    bus.run = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd2;
    step();
    bus.cfg_valid = 1'b0;
    step();
    chk("stopped_apply_phase", 32'(bus.phase), 32'd0);
    chk("stopped_apply_ratio", 32'(bus.active_ratio), 32'd2);
    count_ticks(4, cnt);
    chk("stopped_no_ticks", 32'(cnt), 32'd0);
    bus.run = 1'b1;
    count_ticks(16, cnt);
    chk("div8_tick_count", 32'(cnt), 32'd2);

    // Request equal to the active ratio is a no-op.
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd2;
    step();
    bus.cfg_valid = 1'b0;
    chk("noop_busy", 32'(bus.busy), 32'd0);
    steps(4);

    // Reset while pending discards the pending ratio.
    bus.cfg_valid = 1'b1;
    bus.cfg_ratio = 2'd0;
    step();
    bus.cfg_valid = 1'b0;
    steps(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pend_ratio", 32'(bus.active_ratio), 32'd0);
    chk("rst_pend_busy", 32'(bus.busy), 32'd0);
    steps(20);

    // Randomized traffic; requester holds valid until accepted.
    req_on = 1'b0;
    req_ratio = 0;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.run = ($urandom_range(0, 9) != 0);
      if (!req_on && $urandom_range(0, 5) == 0) begin
        req_on = 1'b1;
        req_ratio = int'($urandom_range(0, 3));
      end
      bus.cfg_valid = req_on;
      bus.cfg_ratio = 2'(req_ratio);
      acc = req_on && !m_busy && !rst;
      step();
      if (acc) req_on = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameters: none; counter width fixed at 4 bits, ratio code fixed at 2 bits.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = phase counter advances and ticks are allowed; 0 = counter frozen, no ticks.
REQ-005 cfg_valid  input  1  request to change the divide ratio.
REQ-006 cfg_ratio  input  2  requested ratio: 0=/2, 1=/4, 2=/8, 3=/16.
REQ-007 cfg_ready  output  1  controller can accept a request.
REQ-008 tick_en  output  1  one-cycle clock-enable strobe at the active ratio.
REQ-009 active_ratio  output  2  ratio currently in force.
REQ-010 phase  output  4  current phase counter value.
REQ-011 busy  output  1  a ratio change is pending.
REQ-012 switch_done  output  1  one-cycle pulse in the cycle after a new ratio takes effect.

Function
REQ-013 The phase counter SHALL increment by 1 per cycle when run=1, hold when run=0, and wrap 15->0.
REQ-014 mask(r) SHALL equal (2^(r+1))-1, i.e. 1, 3, 7 or 15.
REQ-015 tick_en SHALL equal run AND ((phase AND mask(active_ratio)) == mask(active_ratio)), decoded from registered state only, giving one strobe per 2, 4, 8 or 16 running cycles.
REQ-016 The FSM SHALL have two states, IDLE and PEND; cfg_ready=1 only in IDLE; busy=1 only in PEND.
REQ-017 A request SHALL be accepted when cfg_valid=1 and cfg_ready=1; the ratio is then captured in a pending register.
REQ-018 An accepted request with cfg_ratio == active_ratio SHALL be a no-op: stay in IDLE, no switch_done.
REQ-019 An accepted request with a different ratio SHALL move the FSM to PEND on the next edge.
REQ-020 In PEND with run=1 and phase==15, the next edge SHALL:
- load active_ratio from the pending register;
- wrap phase to 0;
- return the FSM to IDLE;
- raise switch_done for one cycle.
REQ-021 In PEND with run=0, the next edge SHALL load active_ratio, clear phase to 0, return the FSM to IDLE and raise switch_done.
REQ-022 During PEND, tick_en SHALL keep using the old ratio; the boundary cycle (phase=15) ticks for every ratio, so no strobe is lost or doubled.
REQ-023 A request accepted in a cycle where phase==15 SHALL wait for the next 16-cycle boundary, not the current one.
REQ-024 cfg_valid while in PEND SHALL be ignored; the requester holds it until cfg_ready=1.
REQ-025 run dropping during PEND SHALL take the REQ-021 path on the next edge.

Reset
REQ-026 While rst=1 at a rising edge, outputs SHALL take these values on that edge:
- phase=0, active_ratio=0 (/2), FSM=IDLE;
- cfg_ready=1, busy=0, switch_done=0;
- tick_en=0.
REQ-027 rst SHALL take priority over every other input.
REQ-028 Reset during PEND SHALL discard the pending ratio.

Structure
REQ-029 Package clk_div_pkg SHALL hold the ratio code constants (RATIO_DIV2..RATIO_DIV16), the FSM state encoding and the mask function.
REQ-030 Sub-module div_phase_counter SHALL contain the 4-bit counter, with enable and synchronous clear; the FSM, pending register and tick decode stay in clk_div_ctrl.

Verification
REQ-031 Reset, then run=1 for 32 cycles -> tick_en high on every odd phase (16 strobes), active_ratio=0, cfg_ready=1.
REQ-032 Request ratio 3 at phase=4 -> busy=1 for phases 5..15, old /2 ticks continue, switch at wrap, switch_done one cycle later; afterwards tick_en only at phase=15, once per 16 cycles.
REQ-033 Request ratio 1 exactly at phase=15 -> no switch at this wrap; switch at the following wrap (16 cycles later).
REQ-034 run=0, request ratio 2 -> ratio applied next edge, phase=0, switch_done pulse, tick_en stays 0 until run=1; then ticks at phases 7 and 15.
REQ-035 Request equal to active_ratio -> cfg_ready stays 1, busy stays 0, no switch_done, tick pattern unchanged.
REQ-036 rst=1 while in PEND -> next cycle IDLE, active_ratio=0, phase=0; the pending ratio is never applied.
